// File: rtl/jpeg_stream_mark.sv
// jpeg_stream_mark: JPEG entropy-stream bit buffer with 0xFF00 unstuffing and
// marker detection.
//   clk, rst            : clock, synchronous active-high reset
//   ai_we/ai_data       : input byte stream, ao_next = ready
//   bit_out/bit_avali   : top OUT_W buffer bits (MSB oldest), window full flag
//   bit_eaten/byte_align: bits consumed this cycle, or drop pad bits to a byte
//   level               : number of valid buffered bits
//   marker_valid/code/ack: held marker and its release
//   err                 : sticky underflow flag
module jpeg_stream_mark #(
    parameter  int BUF_W = 128,
    parameter  int OUT_W = 64,
    localparam int EAT_W = $clog2(OUT_W) + 1,
    localparam int LVL_W = $clog2(BUF_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ai_we,
    input  logic [7:0]       ai_data,
    output logic             ao_next,
    output logic [OUT_W-1:0] bit_out,
    output logic             bit_avali,
    input  logic [EAT_W-1:0] bit_eaten,
    input  logic             byte_align,
    output logic [LVL_W-1:0] level,
    output logic             marker_valid,
    output logic [7:0]       marker_code,
    input  logic             marker_ack,
    output logic             err
);

    localparam logic [1:0] S_NORM = 2'd0;
    localparam logic [1:0] S_FF   = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(BUF_W - 8);
    localparam logic [LVL_W-1:0] LVL_OUT = LVL_W'(OUT_W);

    logic [1:0]       state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic [7:0]       code_q, code_d;
    logic             err_q, err_d;

    logic             accept;
    logic             ins;
    logic [7:0]       ins_byte;
    logic [EAT_W-1:0] eat;
    logic [LVL_W-1:0] eat_l;
    logic [LVL_W-1:0] sh;
    logic [LVL_W-1:0] lvl_ins;
    logic [BUF_W-1:0] merged;
    logic             under;

    assign ao_next = (state_q != S_HOLD) && (lvl_q <= LVL_MAX);
    assign accept  = ai_we & ao_next;

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        ins      = 1'b0;
        ins_byte = ai_data;
        case (state_q)
            S_NORM: begin
                if (accept) begin
                    if (ai_data == 8'hFF) state_d = S_FF;
                    else                  ins     = 1'b1;
                end
            end
            S_FF: begin
                if (accept) begin
                    if (ai_data == 8'h00) begin
                        ins      = 1'b1;
                        ins_byte = 8'hFF;
                        state_d  = S_NORM;
                    end else if (ai_data != 8'hFF) begin
                        code_d  = ai_data;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (marker_ack) state_d = S_NORM;
            end
            default: state_d = S_NORM;
        endcase
    end

    // Alignment drops only the partial byte; it wins over bit_eaten.
    assign eat   = byte_align ? EAT_W'(lvl_q[2:0]) : bit_eaten;
    assign eat_l = LVL_W'(eat);
    assign under = eat_l > lvl_q;

    // New byte lands just below the valid bits; only used when accepting,
    // where lvl_q <= LVL_MAX keeps the shift in range.
    assign sh      = LVL_MAX - lvl_q;
    assign merged  = ins ? (buf_q | (BUF_W'(ins_byte) << sh)) : buf_q;
    assign lvl_ins = ins ? lvl_q + LVL_W'(8) : lvl_q;

    always_comb begin
        buf_d = under ? '0 : (merged << eat);
        lvl_d = under ? '0 : (lvl_ins - eat_l);
        err_d = err_q | under;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_NORM;
            buf_q   <= '0;
            lvl_q   <= '0;
            code_q  <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            lvl_q   <= lvl_d;
            code_q  <= code_d;
            err_q   <= err_d;
        end
    end

    assign bit_out      = buf_q[BUF_W-1 -: OUT_W];
    assign bit_avali    = lvl_q >= LVL_OUT;
    assign level        = lvl_q;
    assign marker_valid = state_q == S_HOLD;
    assign marker_code  = code_q;
    assign err          = err_q;

endmodule

// File: tb/tb_jpeg_stream_mark.sv
// tb_jpeg_stream_mark: directed vector table, a throughput sequence and a
// randomized run against a bit-queue reference model.
module tb_jpeg_stream_mark;

    localparam int BUF_W = 128;
    localparam int OUT_W = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        ai_we;
    logic [7:0]  ai_data;
    logic        ao_next;
    logic [63:0] bit_out;
    logic        bit_avali;
    logic [6:0]  bit_eaten;
    logic        byte_align;
    logic [7:0]  level;
    logic        marker_valid;
    logic [7:0]  marker_code;
    logic        marker_ack;
    logic        err;

    always #5 clk = ~clk;

    jpeg_stream_mark #(.BUF_W(BUF_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .ai_we(ai_we), .ai_data(ai_data),
        .ao_next(ao_next), .bit_out(bit_out), .bit_avali(bit_avali),
        .bit_eaten(bit_eaten), .byte_align(byte_align), .level(level),
        .marker_valid(marker_valid), .marker_code(marker_code),
        .marker_ack(marker_ack), .err(err)
    );

    typedef struct {
        logic        r, w;
        logic [7:0]  d;
        logic [6:0]  e;
        logic        al, ack;
        logic [7:0]  lv;
        logic [63:0] bo;
        logic        mv;
        logic [7:0]  mc;
        logic        nx, er;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    bit         mq[$];
    bit         m_ff, m_hold, m_err;
    logic [7:0] m_code;

    function automatic logic [63:0] pref(logic [63:0] v, int n);
        logic [63:0] m;
        m = (n >= 64) ? {64{1'b1}} : ~({64{1'b1}} >> n);
        return v & m;
    endfunction

    task automatic add(input logic r, w, input logic [7:0] d,
                       input logic [6:0] e, input logic al, ack,
                       input logic [7:0] lv, input logic [63:0] bo,
                       input logic mv, input logic [7:0] mc,
                       input logic nx, er);
        vec_t v;
        v.r = r; v.w = w; v.d = d; v.e = e; v.al = al; v.ack = ack;
        v.lv = lv; v.bo = bo; v.mv = mv; v.mc = mc; v.nx = nx; v.er = er;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, w, input logic [7:0] d,
                         input logic [6:0] e, input logic al, ack);
        rst = r; ai_we = w; ai_data = d; bit_eaten = e;
        byte_align = al; marker_ack = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [7:0] lv,
                         input logic [63:0] bo, input logic av, mv,
                         input logic [7:0] mc, input logic nx, er);
        n_chk++;
        if (level === lv && bit_out === bo && bit_avali === av &&
            marker_valid === mv && marker_code === mc &&
            ao_next === nx && err === er)
            n_pass++;
        else
            $display("FAIL %s: got lvl=%0d out=%h av=%b mv=%b mc=%h nx=%b err=%b want lvl=%0d out=%h av=%b mv=%b mc=%h nx=%b err=%b",
                     nm, level, bit_out, bit_avali, marker_valid,
                     marker_code, ao_next, err, lv, bo, av, mv, mc, nx, er);
    endtask

    task automatic model_step(input logic r, w, input logic [7:0] d,
                              input logic [6:0] e, input logic al, ack);
        int         sz, ev;
        bit         rdy, pushb;
        logic [7:0] pb;
        if (r) begin
            mq.delete();
            m_ff = 0; m_hold = 0; m_err = 0; m_code = 8'h00;
            return;
        end
        sz    = mq.size();
        rdy   = !m_hold && sz <= BUF_W - 8;
        ev    = al ? sz % 8 : int'(e);
        pushb = 0;
        pb    = 8'h00;
        if (m_hold) begin
            if (ack) m_hold = 0;
        end else if (w && rdy) begin
            if (!m_ff) begin
                if (d == 8'hFF) m_ff = 1;
                else begin pushb = 1; pb = d; end
            end else if (d == 8'h00) begin
                pushb = 1; pb = 8'hFF; m_ff = 0;
            end else if (d != 8'hFF) begin
                m_code = d; m_hold = 1; m_ff = 0;
            end
        end
        if (ev > sz) begin
            mq.delete();
            m_err = 1;
        end else begin
            if (pushb)
                for (int i = 7; i >= 0; i--) mq.push_back(pb[i]);
            repeat (ev) void'(mq.pop_front());
        end
    endtask

    task automatic model_check(input int cyc);
        logic [63:0] bo;
        int          sz;
        sz = mq.size();
        bo = '0;
        for (int i = 0; i < 64; i++)
            if (i < sz) bo[63-i] = mq[i];
        check($sformatf("rand[%0d]", cyc), 8'(sz), bo, sz >= 64, m_hold,
              m_code, !m_hold && sz <= BUF_W - 8, m_err);
    endtask

    initial begin
        logic [63:0] a8;
        logic [63:0] ones;
        a8   = 64'h123456789ABCDEF0;
        ones = 64'h1111111111111111;

        add(1,0,8'h00,0,0,0, 0,64'h0,0,8'h00,1,0);
        for (int i = 0; i < 8; i++)
            add(0,1,a8[63-8*i -: 8],0,0,0, 8'(8*(i+1)),pref(a8,8*(i+1)),0,8'h00,1,0);
        add(0,0,8'h00,64,0,0, 0,64'h0,0,8'h00,1,0);
        add(0,1,8'hFF,0,0,0, 0,64'h0,0,8'h00,1,0);
        add(0,1,8'h00,0,0,0, 8,64'hFF00_0000_0000_0000,0,8'h00,1,0);
        add(0,1,8'hAB,0,0,0, 16,64'hFFAB_0000_0000_0000,0,8'h00,1,0);
        add(0,0,8'h00,16,0,0, 0,64'h0,0,8'h00,1,0);
        add(0,1,8'h5A,0,0,0, 8,64'h5A00_0000_0000_0000,0,8'h00,1,0);
        add(0,1,8'hFF,0,0,0, 8,64'h5A00_0000_0000_0000,0,8'h00,1,0);
        add(0,1,8'hFF,0,0,0, 8,64'h5A00_0000_0000_0000,0,8'h00,1,0);
        add(0,1,8'hD3,0,0,0, 8,64'h5A00_0000_0000_0000,1,8'hD3,0,0);
        add(0,1,8'h11,4,0,0, 4,64'hA000_0000_0000_0000,1,8'hD3,0,0);
        add(0,0,8'h00,0,0,1, 4,64'hA000_0000_0000_0000,0,8'hD3,1,0);
        add(0,0,8'h00,4,0,0, 0,64'h0,0,8'hD3,1,0);
        add(0,1,8'h22,0,0,1, 8,64'h2200_0000_0000_0000,0,8'hD3,1,0);
        add(0,0,8'h00,8,0,0, 0,64'h0,0,8'hD3,1,0);
        add(0,1,8'hB6,0,0,0, 8,64'hB600_0000_0000_0000,0,8'hD3,1,0);
        add(0,1,8'h6D,3,0,0, 13,64'hB368_0000_0000_0000,0,8'hD3,1,0);
        add(0,0,8'h00,7,1,0, 8,64'h6D00_0000_0000_0000,0,8'hD3,1,0);
        add(0,0,8'h00,8,0,0, 0,64'h0,0,8'hD3,1,0);
        add(0,1,8'h07,0,0,0, 8,64'h0700_0000_0000_0000,0,8'hD3,1,0);
        add(0,0,8'h00,5,0,0, 3,64'hE000_0000_0000_0000,0,8'hD3,1,0);
        add(0,0,8'h00,5,0,0, 0,64'h0,0,8'hD3,1,1);
        add(0,0,8'h00,0,0,0, 0,64'h0,0,8'hD3,1,1);
        add(1,0,8'h00,0,0,0, 0,64'h0,0,8'h00,1,0);
        add(0,1,8'hFF,0,0,0, 0,64'h0,0,8'h00,1,0);
        add(1,1,8'h12,0,0,0, 0,64'h0,0,8'h00,1,0);
        add(0,1,8'h00,0,0,0, 8,64'h0,0,8'h00,1,0);
        add(0,0,8'h00,8,0,0, 0,64'h0,0,8'h00,1,0);
        add(0,1,8'hFF,0,0,0, 0,64'h0,0,8'h00,1,0);
        add(0,1,8'hD3,0,0,0, 0,64'h0,1,8'hD3,0,0);
        add(1,1,8'h44,0,0,0, 0,64'h0,0,8'h00,1,0);
        for (int i = 1; i <= 16; i++)
            add(0,1,8'h11,0,0,0, 8'(8*i),pref(ones,8*i),0,8'h00,(8*i) <= 120,0);
        add(0,1,8'h22,0,0,0, 128,ones,0,8'h00,0,0);
        add(0,1,8'h22,8,0,0, 120,ones,0,8'h00,1,0);
        add(0,1,8'h11,8,0,0, 120,ones,0,8'h00,1,0);
        add(0,0,8'h00,8,0,0, 112,ones,0,8'h00,1,0);
        add(0,0,8'h00,64,0,0, 48,pref(ones,48),0,8'h00,1,0);
        add(0,0,8'h00,48,0,0, 0,64'h0,0,8'h00,1,0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].r, tbl[i].w, tbl[i].d, tbl[i].e, tbl[i].al, tbl[i].ack);
            check($sformatf("tbl[%0d]", i), tbl[i].lv, tbl[i].bo,
                  tbl[i].lv >= 64, tbl[i].mv, tbl[i].mc, tbl[i].nx, tbl[i].er);
        end

        drive(0,1,8'h80,0,0,0);
        for (int i = 0; i < 10; i++) begin
            drive(0,1,8'h80,8,0,0);
            check($sformatf("thru[%0d]", i), 8, 64'h8000_0000_0000_0000,
                  0, 0, 8'h00, 1, 0);
        end

        drive(1,0,8'h00,0,0,0);
        model_step(1,0,8'h00,0,0,0);
        model_check(-1);
        for (int c = 0; c < 4000; c++) begin
            logic       r, w, al, ack;
            logic [7:0] d;
            logic [6:0] e;
            int         sz, pk;
            sz  = mq.size();
            r   = $urandom_range(0, 399) == 0;
            w   = $urandom_range(0, 9) < 7;
            pk  = $urandom_range(0, 9);
            d   = (pk < 3) ? 8'hFF : (pk == 3) ? 8'h00 : 8'($urandom_range(0, 255));
            al  = $urandom_range(0, 19) == 0;
            ack = $urandom_range(0, 3) == 0;
            if ($urandom_range(0, 49) == 0)
                e = 7'($urandom_range(0, 64));
            else
                e = 7'($urandom_range(0, (sz < 14) ? sz : 14));
            drive(r, w, d, e, al, ack);
            model_step(r, w, d, e, al, ack);
            model_check(c);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
